// File: rtl/cpc_io_bridge.sv
// CPC-to-ATMega I/O bridge: decodes CPC port writes into a channel-tagged FIFO
// drained by the ATMega, and serves CPC reads from ATMega-loaded response registers.
module cpc_io_bridge #(
  parameter int                 DATA_W     = 8,
  parameter int                 N_CH       = 3,
  parameter logic [16*N_CH-1:0] CH_ADR     = {16'hFBFE, 16'hFAEE, 16'hFBEE},
  parameter int                 FIFO_DEPTH = 16,
  parameter logic [15:0]        STATUS_ADR = 16'hFBEF,
  parameter logic [7:0]         AMDRUM_HI  = 8'hFF
) (
  input  logic              iCLK,
  input  logic              i_RESET,
  input  logic              i_IORQ,
  input  logic              i_RD,
  input  logic              i_WR,
  input  logic [15:0]       iADR,
  inout  wire  [DATA_W-1:0] ioCPC_DATA,
  input  logic              iAMDRUM,
  output logic [DATA_W-1:0] oATMEGA_DATA,
  output logic [2:0]        oATMEGA_CH,
  output logic              oATMEGA_VALID,
  input  logic              iATMEGA_ACK,
  input  logic [DATA_W-1:0] iATMEGA_DATA,
  input  logic [2:0]        iATMEGA_CH,
  input  logic              iATMEGA_LOAD,
  output logic              oFIFO_FULL,
  output logic              oOVERFLOW
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [2:0]        ch;
    logic [DATA_W-1:0] data;
  } entry_t;

  // ---------------------------------------------------------------- sync
  logic [1:0] iorq_sq, rd_sq, wr_sq;

  // NOTE: strobes are active-low, so synchronisers reset to the idle level 1;
  // a write already low at release then shows up as a fresh edge exactly once.
  always_ff @(posedge iCLK or negedge i_RESET) begin
    if (!i_RESET) begin
      iorq_sq <= 2'b11;
      rd_sq   <= 2'b11;
      wr_sq   <= 2'b11;
    end else begin
      iorq_sq <= {iorq_sq[0], i_IORQ};
      rd_sq   <= {rd_sq[0], i_RD};
      wr_sq   <= {wr_sq[0], i_WR};
    end
  end

  logic wr_act, rd_act, wr_act_q, rd_act_q, wr_start, rd_start;
  assign wr_act   = !iorq_sq[1] && !wr_sq[1];
  assign rd_act   = !iorq_sq[1] && !rd_sq[1];
  assign wr_start = wr_act && !wr_act_q;
  assign rd_start = rd_act && !rd_act_q;

  // ---------------------------------------------------------------- decode
  logic       adr_hit, is_status, amd_hit;
  logic [2:0] adr_ch;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    adr_hit = 1'b0;
    adr_ch  = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (iADR == CH_ADR[16*k +: 16]) begin
        adr_hit = 1'b1;
        adr_ch  = 3'(k);
      end
    end
  end

  assign is_status = (iADR == STATUS_ADR);
  assign amd_hit   = iAMDRUM && (iADR[15:8] == AMDRUM_HI);

  logic       wr_hit, rd_ch_hit, rd_low;
  logic [2:0] wr_ch;
  assign wr_hit    = !is_status && (adr_hit || amd_hit);
  assign wr_ch     = amd_hit ? 3'd0 : adr_ch;
  assign rd_low    = !i_IORQ && !i_RD;
  assign rd_ch_hit = adr_hit && !iAMDRUM && !is_status;

  // ---------------------------------------------------------------- FIFO
  entry_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [4:0]      count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            full, empty, pop, push_req, push_ok, ovf_set, ovf_clr;
  entry_t          head;

  assign full     = (count_q == 5'(FIFO_DEPTH));
  assign empty    = (count_q == 5'd0);
  assign pop      = !empty && iATMEGA_ACK;
  assign push_req = wr_start && wr_hit;
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign count_d  = count_q + {4'd0, push_ok} - {4'd0, pop};
  assign ovf_d    = ovf_set || (ovf_q && !ovf_clr);

  // NOTE: storage has no reset; head outputs are masked while empty instead.
  always_ff @(posedge iCLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= '{ch: wr_ch, data: ioCPC_DATA};
  end

  assign head          = mem_q[rd_ptr_q];
  assign oATMEGA_VALID = !empty;
  assign oATMEGA_DATA  = empty ? '0 : head.data;
  assign oATMEGA_CH    = empty ? 3'd0 : head.ch;
  assign oFIFO_FULL    = full;
  assign oOVERFLOW     = ovf_q;

  // ---------------------------------------------------------------- read tracking
  logic       rd_hit_q, rd_stat_q, cur_hit, ch_busy;
  logic [2:0] rd_ch_q, cur_ch;

  // The read's address is captured as the synchronised strobe goes active.
  assign cur_hit = rd_start ? rd_ch_hit : rd_hit_q;
  assign cur_ch  = rd_start ? adr_ch : rd_ch_q;
  assign ch_busy = rd_act && cur_hit;
  assign ovf_clr = rd_act_q && !rd_act && rd_stat_q;

  // ---------------------------------------------------------------- responses
  logic [DATA_W-1:0] resp_q [8];
  logic [DATA_W-1:0] resp_d [8];
  logic              pend_vld_q, pend_vld_d;
  logic [2:0]        pend_ch_q, pend_ch_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic              load_ok;

  assign load_ok = iATMEGA_LOAD && (32'(iATMEGA_CH) < N_CH);

  always_comb begin
    resp_d      = resp_q;
    pend_vld_d  = pend_vld_q;
    pend_ch_d   = pend_ch_q;
    pend_data_d = pend_data_q;
    if (pend_vld_q && !(ch_busy && cur_ch == pend_ch_q)) begin
      resp_d[pend_ch_q] = pend_data_q;
      pend_vld_d        = 1'b0;
    end
    if (load_ok) begin
      if (ch_busy && cur_ch == iATMEGA_CH) begin
        pend_vld_d  = 1'b1;
        pend_ch_d   = iATMEGA_CH;
        pend_data_d = iATMEGA_DATA;
      end else begin
        resp_d[iATMEGA_CH] = iATMEGA_DATA;
      end
    end
  end

  // ---------------------------------------------------------------- state
  always_ff @(posedge iCLK or negedge i_RESET) begin
    if (!i_RESET) begin
      wr_act_q    <= 1'b0;
      rd_act_q    <= 1'b0;
      rd_hit_q    <= 1'b0;
      rd_stat_q   <= 1'b0;
      rd_ch_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_ch_q   <= '0;
      pend_data_q <= '0;
      for (int i = 0; i < 8; i++) resp_q[i] <= '0;
    end else begin
      wr_act_q <= wr_act;
      rd_act_q <= rd_act;
      if (rd_start) begin
        rd_hit_q  <= rd_ch_hit;
        rd_ch_q   <= adr_ch;
        rd_stat_q <= is_status;
      end
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      pend_vld_q  <= pend_vld_d;
      pend_ch_q   <= pend_ch_d;
      pend_data_q <= pend_data_d;
      resp_q      <= resp_d;
    end
  end

  // ---------------------------------------------------------------- CPC read bus
  logic [DATA_W-1:0] rd_data;
  logic              rd_drive;

  always_comb begin
    rd_data = '0;
    if (is_status) rd_data[7:0] = {full, empty, ovf_q, count_q};
    else           rd_data      = resp_q[adr_ch];
  end

  assign rd_drive   = rd_low && (is_status || rd_ch_hit);
  assign ioCPC_DATA = rd_drive ? rd_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_cpc_io_bridge.sv
// Self-checking bench for cpc_io_bridge: directed scenarios plus randomized
// traffic compared against a queue/array model of the bridge.
module tb_cpc_io_bridge;

  localparam int          DEPTH  = 16;
  localparam logic [15:0] STATUS = 16'hFBEF;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iorq = 1'b1, rd = 1'b1, wr = 1'b1;
  logic [15:0] adr = 16'h0000;
  logic        amd = 1'b0;
  logic        ack = 1'b0, load = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic [2:0]  ld_ch = 3'd0;
  logic [7:0]  drv = 8'h00;
  logic        drv_en = 1'b0;
  wire  [7:0]  dq;
  logic [7:0]  a_data;
  logic [2:0]  a_ch;
  logic        a_valid, full, ovf;

  assign dq = drv_en ? drv : 8'hzz;

  cpc_io_bridge #(
    .DATA_W(8), .N_CH(3), .CH_ADR({16'hFBFE, 16'hFAEE, 16'hFBEE}),
    .FIFO_DEPTH(DEPTH), .STATUS_ADR(STATUS), .AMDRUM_HI(8'hFF)
  ) dut (
    .iCLK(clk), .i_RESET(rst_n), .i_IORQ(iorq), .i_RD(rd), .i_WR(wr),
    .iADR(adr), .ioCPC_DATA(dq), .iAMDRUM(amd),
    .oATMEGA_DATA(a_data), .oATMEGA_CH(a_ch), .oATMEGA_VALID(a_valid),
    .iATMEGA_ACK(ack), .iATMEGA_DATA(ld_data), .iATMEGA_CH(ld_ch),
    .iATMEGA_LOAD(load), .oFIFO_FULL(full), .oOVERFLOW(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ model
  ent_t        mq[$];
  bit          m_ovf;
  logic [7:0]  m_resp [3];
  logic [15:0] ch_tab [3];
  int          n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_ch(input logic [15:0] a, input bit amdrum);
    if (a == STATUS) return -1;
    if (amdrum && a[15:8] == 8'hFF) return 0;
    for (int k = 0; k < 3; k++) if (a == ch_tab[k]) return k;
    return -1;
  endfunction

  function automatic logic [7:0] stat_exp();
    return {mq.size() == DEPTH, mq.size() == 0, m_ovf, 5'(mq.size())};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 0;
    for (int k = 0; k < 3; k++) m_resp[k] = 8'h00;
  endtask

  // ------------------------------------------------------------ bus tasks
  task automatic cpc_write(input logic [15:0] a, input logic [7:0] d, input bit co_ack,
                           output logic v_e2, output logic v_e3);
    int ch;
    @(negedge clk); adr = a; drv = d; drv_en = 1'b1; iorq = 1'b0; wr = 1'b0;
    @(negedge clk);
    @(negedge clk); v_e2 = a_valid;
    if (co_ack) begin
      check("co_head_valid", a_valid, 1);
      check("co_head", {a_ch, a_data}, {mq[0].ch, mq[0].data});
      ack = 1'b1;
    end
    @(negedge clk); v_e3 = a_valid; ack = 1'b0;
    @(negedge clk); iorq = 1'b1; wr = 1'b1; drv_en = 1'b0;
    repeat (3) @(negedge clk);
    ch = model_ch(a, amd);
    if (co_ack) void'(mq.pop_front());
    if (ch >= 0) begin
      if (mq.size() == DEPTH) m_ovf = 1;
      else mq.push_back('{ch: 3'(ch), data: d});
    end
  endtask

  task automatic wr_simple(input logic [15:0] a, input logic [7:0] d);
    logic v2, v3;
    cpc_write(a, d, 1'b0, v2, v3);
  endtask

  task automatic pop_check(input string tag);
    ent_t e;
    @(negedge clk);
    check({tag, "_valid"}, a_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      e = mq.pop_front();
      check({tag, "_ch"}, a_ch, e.ch);
      check({tag, "_data"}, a_data, e.data);
      ack = 1'b1;
      @(negedge clk); ack = 1'b0;
    end
  endtask

  task automatic rd_begin(input logic [15:0] a);
    @(negedge clk); adr = a; iorq = 1'b0; rd = 1'b0;
    #1;
  endtask

  task automatic rd_end();
    @(negedge clk); iorq = 1'b1; rd = 1'b1;
    repeat (3) @(negedge clk);
    if (adr == STATUS) m_ovf = 0;
  endtask

  task automatic cpc_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    rd_begin(a);
    check(tag, dq, exp);
    repeat (3) @(negedge clk);
    check({tag, "_held"}, dq, exp);
    rd_end();
  endtask

  task automatic atm_load(input logic [2:0] c, input logic [7:0] d);
    @(negedge clk); ld_ch = c; ld_data = d; load = 1'b1;
    @(negedge clk); load = 1'b0;
    if (c < 3) m_resp[c] = d;
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    logic v2, v3;
    int   op, sel, k;
    logic [15:0] ra;

    ch_tab[0] = 16'hFBEE; ch_tab[1] = 16'hFAEE; ch_tab[2] = 16'hFBFE;
    model_reset();

    // Reset state
    #1;
    check("rst_valid", a_valid, 0);
    check("rst_full", full, 0);
    check("rst_ovf", ovf, 0);
    check("rst_head", {a_ch, a_data}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Three writes, VALID latency, ordered pops
    cpc_write(16'hFBEE, 8'h11, 1'b0, v2, v3);
    check("lat_valid_e2", v2, 0);
    check("lat_valid_e3", v3, 1);
    wr_simple(16'hFAEE, 8'h22);
    wr_simple(16'hFBFE, 8'h33);
    repeat (3) pop_check("pop3");
    pop_check("pop3_empty");

    // ACK while empty is ignored
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    cpc_read("stat_empty", STATUS, stat_exp());

    // Fill to full, then overflow
    for (int i = 0; i < DEPTH; i++) wr_simple(16'hFBEE, 8'(8'h40 + i));
    check("full_flag", full, 1);
    check("full_no_ovf", ovf, 0);
    wr_simple(16'hFBEE, 8'hEE);
    check("ovf_set", ovf, m_ovf);
    cpc_read("stat_full_ovf", STATUS, stat_exp());
    check("ovf_cleared", ovf, 0);

    // Write coincident with pop while full
    cpc_write(16'hFBEE, 8'hC3, 1'b1, v2, v3);
    check("co_no_ovf", ovf, 0);
    cpc_read("stat_co", STATUS, stat_exp());
    for (int i = 0; i < DEPTH; i++) pop_check("drain");
    pop_check("drain_empty");

    // Response loads and pending update during a read
    atm_load(3'd1, 8'hA5);
    cpc_read("resp_a5", 16'hFAEE, m_resp[1]);
    rd_begin(16'hFAEE);
    check("mid_rd_start", dq, 8'hA5);
    repeat (3) @(negedge clk);
    atm_load(3'd1, 8'h66);
    atm_load(3'd1, 8'h5A);
    check("mid_rd_hold", dq, 8'hA5);
    @(negedge clk);
    check("mid_rd_hold2", dq, 8'hA5);
    rd_end();
    cpc_read("resp_after_pend", 16'hFAEE, 8'h5A);
    atm_load(3'd5, 8'h99);
    cpc_read("resp_bad_idx_ch1", 16'hFAEE, m_resp[1]);

    // AMDRUM mode
    atm_load(3'd0, 8'hFF);
    amd = 1'b1;
    wr_simple(16'hFF40, 8'h7F);
    rd_begin(16'hFBEE);
    check("amd_rd_undriven", dq === 8'hFF, 0);
    rd_end();
    cpc_read("amd_stat", STATUS, stat_exp());
    amd = 1'b0;
    pop_check("amd_pop");

    // Reset with queued entries and overflow set
    for (int i = 0; i < DEPTH + 1; i++) wr_simple(16'hFBFE, 8'(i));
    for (int i = 0; i < DEPTH - 5; i++) pop_check("pre_rst");
    check("pre_rst_ovf", ovf, 1);
    atm_load(3'd1, 8'h77);
    @(negedge clk); rst_n = 1'b0;
    #1;
    model_reset();
    check("rst2_valid", a_valid, 0);
    check("rst2_ovf", ovf, 0);
    check("rst2_full", full, 0);
    check("rst2_head", {a_ch, a_data}, 0);
    adr = 16'hFAEE; iorq = 1'b0; rd = 1'b0;
    #1 check("rst2_resp", dq, 8'h00);
    adr = STATUS;
    #1 check("rst2_stat", dq, stat_exp());
    iorq = 1'b1; rd = 1'b1;

    // Write held low across reset release is pushed once
    @(negedge clk); adr = 16'hFBFE; drv = 8'h9C; drv_en = 1'b1; iorq = 1'b0; wr = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    iorq = 1'b1; wr = 1'b1; drv_en = 1'b0;
    repeat (3) @(negedge clk);
    mq.push_back('{ch: 3'd2, data: 8'h9C});
    pop_check("inflight");
    pop_check("inflight_once");

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        sel = $urandom_range(0, 5);
        case (sel)
          0, 1, 2: ra = ch_tab[sel];
          3:       ra = STATUS;
          4:       ra = 16'($urandom);
          default: ra = {8'hFF, 8'($urandom)};
        endcase
        amd = ($urandom_range(0, 3) == 0);
        wr_simple(ra, 8'($urandom));
        amd = 1'b0;
      end else if (op <= 6) begin
        pop_check("rnd_pop");
      end else if (op == 7) begin
        atm_load(3'($urandom_range(0, 7)), 8'($urandom));
      end else if (op == 8) begin
        k = $urandom_range(0, 2);
        cpc_read("rnd_resp", ch_tab[k], m_resp[k]);
      end else begin
        cpc_read("rnd_stat", STATUS, stat_exp());
      end
      check("rnd_full", full, mq.size() == DEPTH);
      check("rnd_ovf", ovf, m_ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
